// File: rtl/inter_packet_delay_v2.sv
// ---------------------------------------------------------------------------
// inter_packet_delay_v2
//
// AXI4-Stream inter-packet gap enforcer. Beats pass through combinationally;
// after each packet the gate is held closed for a programmable number of
// cycles before the next start-of-packet (SOP) is allowed.
//
// Gap modes:
//   gap_mode = 0 : end-to-start   (tlast accepted at T -> next SOP >= T+1+D)
//   gap_mode = 1 : start-to-start (SOP at S, tlast at T -> next SOP >= max(S+D, T+1))
// D is taken at SOP from delay_reg_val (use_reg_val = 1) or from
// s_axis_tuser[C_TUSER_DELAY_OFFSET +: C_DELAY_WIDTH] (use_reg_val = 0).
// ipd_en and gap_mode are sampled at SOP as well.
//
// Ports:
//   axi_aclk, axi_areset        clock, async active-high reset
//   s_axis_*                    slave stream (tdata/tstrb/tuser/tvalid/tlast, tready out)
//   m_axis_*                    master stream (tdata/tstrb/tuser/tvalid/tlast, tready in)
//   sw_rst                      synchronous level reset of the gap logic
//   ipd_en                      1 = enforce gaps, 0 = pass-through
//   use_reg_val                 delay source select
//   gap_mode                    0 = end-to-start, 1 = start-to-start
//   delay_reg_val               register-supplied delay in cycles
//   busy                        high while the gate is closed (WAIT)
//   stat_pkt_count,
//   stat_gap_cycles             only with INTER_PACKET_DELAY_STATS_EN defined
//
// Optional feature macro: INTER_PACKET_DELAY_STATS_EN
// C_S_AXIS_DATA_WIDTH / C_S_AXIS_TUSER_WIDTH must equal their master twins.
// ---------------------------------------------------------------------------
// state | meaning
// IDLE  | between packets, gate open, waiting for SOP
// PASS  | mid-packet, gate open
// WAIT  | gate closed, cnt counting down to the next allowed SOP
// ---------------------------------------------------------------------------
module inter_packet_delay_v2 #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_DELAY_WIDTH        = 32,
  parameter int C_TUSER_DELAY_OFFSET = 32
) (
  input  logic                              axi_aclk,
  input  logic                              axi_areset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tlast,
  output logic                              s_axis_tready,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  input  logic                              sw_rst,
  input  logic                              ipd_en,
  input  logic                              use_reg_val,
  input  logic                              gap_mode,
  input  logic [C_DELAY_WIDTH-1:0]          delay_reg_val,
`ifdef INTER_PACKET_DELAY_STATS_EN
  output logic [31:0]                       stat_pkt_count,
  output logic [31:0]                       stat_gap_cycles,
`endif
  output logic                              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [C_DELAY_WIDTH-1:0] ONE = C_DELAY_WIDTH'(1);

  state_t                   state;
  logic [C_DELAY_WIDTH-1:0] cnt;
  logic [C_DELAY_WIDTH-1:0] dly_lat;
  logic                     en_lat;
  logic                     mode_lat;

  logic                     gate;
  logic                     hs;
  logic [C_DELAY_WIDTH-1:0] sop_dly;
  logic [C_DELAY_WIDTH-1:0] sop_dly_m1;
  logic [C_DELAY_WIDTH-1:0] cnt_dec;

  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tstrb  = s_axis_tstrb;
  assign m_axis_tuser  = s_axis_tuser;
  assign m_axis_tlast  = s_axis_tlast;

  assign gate          = ~axi_areset & (state != WAIT);
  assign m_axis_tvalid = s_axis_tvalid & gate;
  assign s_axis_tready = m_axis_tready & gate;
  assign hs            = s_axis_tvalid & s_axis_tready;

  assign sop_dly    = use_reg_val ? delay_reg_val
                                  : s_axis_tuser[C_TUSER_DELAY_OFFSET +: C_DELAY_WIDTH];
  // Saturating decrements: the counter never wraps below zero.
  assign sop_dly_m1 = (sop_dly == '0) ? '0 : sop_dly - ONE;
  assign cnt_dec    = (cnt == '0)     ? '0 : cnt - ONE;

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      state    <= IDLE;
      cnt      <= '0;
      dly_lat  <= '0;
      en_lat   <= 1'b0;
      mode_lat <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hs) begin
            dly_lat  <= sop_dly;
            // A software reset seen at SOP cancels the gap for this packet.
            en_lat   <= ipd_en & ~sw_rst;
            mode_lat <= gap_mode;
            if (s_axis_tlast) begin
              if (!ipd_en || sw_rst) begin
                cnt   <= '0;
                state <= IDLE;
                busy  <= 1'b0;
              end else if (!gap_mode) begin
                cnt   <= sop_dly;
                state <= (sop_dly != '0) ? WAIT : IDLE;
                busy  <= (sop_dly != '0);
              end else begin
                cnt   <= sop_dly_m1;
                state <= (sop_dly_m1 != '0) ? WAIT : IDLE;
                busy  <= (sop_dly_m1 != '0);
              end
            end else begin
              // Start-to-start: the SOP cycle itself is the first gap cycle.
              cnt   <= gap_mode ? sop_dly_m1 : '0;
              state <= PASS;
            end
          end else if (sw_rst) begin
            cnt <= '0;
          end
        end

        PASS: begin
          if (mode_lat) cnt <= cnt_dec;
          if (sw_rst) begin
            cnt    <= '0;
            en_lat <= 1'b0;
          end
          if (hs && s_axis_tlast) begin
            if (!en_lat || sw_rst) begin
              cnt   <= '0;
              state <= IDLE;
              busy  <= 1'b0;
            end else if (!mode_lat) begin
              cnt   <= dly_lat;
              state <= (dly_lat != '0) ? WAIT : IDLE;
              busy  <= (dly_lat != '0);
            end else begin
              // cnt_dec is the remaining start-to-start budget after this cycle.
              state <= (cnt_dec != '0) ? WAIT : IDLE;
              busy  <= (cnt_dec != '0);
            end
          end
        end

        WAIT: begin
          if (sw_rst || cnt == '0 || cnt == ONE) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt_dec;
          end
        end

        default: begin
          cnt   <= '0;
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef INTER_PACKET_DELAY_STATS_EN
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      stat_pkt_count  <= '0;
      stat_gap_cycles <= '0;
    end else if (sw_rst) begin
      stat_pkt_count  <= '0;
      stat_gap_cycles <= '0;
    end else begin
      if (hs && s_axis_tlast) stat_pkt_count  <= stat_pkt_count + 32'd1;
      if (state == WAIT)      stat_gap_cycles <= stat_gap_cycles + 32'd1;
    end
  end
`endif

endmodule
